// File: rtl/memory_access_stage.sv
// Memory access stage: holds one execute-stage operation, performs the data-memory
// request/ack handshake with an ack timeout, and emits a one-cycle writeback/branch packet.
module memory_access_stage #(
  parameter  int unsigned ACK_TIMEOUT = 15,
  localparam int unsigned DATA_W      = 32,
  localparam int unsigned REG_W       = 5
) (
  input  logic              clock,
  input  logic              resetN,
  input  logic              inValid,
  output logic              inReady,
  input  logic [DATA_W-1:0] ALUResult,
  input  logic              zero,
  input  logic [DATA_W-1:0] storeData,
  input  logic [REG_W-1:0]  destRegister,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              MemToReg,
  input  logic              RegWrite,
  input  logic              Branch,
  input  logic [DATA_W-1:0] branchTarget,
  output logic              memRequest,
  output logic              memWriteEnable,
  output logic [DATA_W-1:0] memAddress,
  output logic [DATA_W-1:0] memWriteData,
  input  logic [DATA_W-1:0] memReadData,
  input  logic              memAck,
  output logic              wbValid,
  output logic              wbRegWrite,
  output logic [REG_W-1:0]  wbRegister,
  output logic [DATA_W-1:0] wbData,
  output logic              branchTaken,
  output logic [DATA_W-1:0] branchAddress,
  output logic              misaligned,
  output logic              timeoutError
);

  localparam int unsigned CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;

  state_t state_q, state_d;

  // Captured operation
  logic [DATA_W-1:0] alu_q, alu_d;
  logic [DATA_W-1:0] store_q, store_d;
  logic [DATA_W-1:0] target_q, target_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [REG_W-1:0]  dest_q, dest_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic              mem_to_reg_q, mem_to_reg_d;
  logic              reg_write_q, reg_write_d;
  logic              branch_q, branch_d;
  logic              zero_q, zero_d;
  logic              mis_flag_q, mis_flag_d;
  logic              to_flag_q, to_flag_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Registered outputs
  logic              in_ready_q, in_ready_d;
  logic              mem_request_q, mem_request_d;
  logic              mem_we_q, mem_we_d;
  logic              wb_valid_q, wb_valid_d;
  logic              wb_reg_write_q, wb_reg_write_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              branch_taken_q, branch_taken_d;
  logic              misaligned_q, misaligned_d;
  logic              timeout_q, timeout_d;

  logic mem_op_c;
  logic addr_bad_c;
  logic is_load_c;

  // Next state, capture and output computation; outputs are derived from next-state values
  always_comb begin
    state_d      = state_q;
    alu_d        = alu_q;
    store_d      = store_q;
    target_d     = target_q;
    rdata_d      = rdata_q;
    dest_d       = dest_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_to_reg_d = mem_to_reg_q;
    reg_write_d  = reg_write_q;
    branch_d     = branch_q;
    zero_d       = zero_q;
    mis_flag_d   = mis_flag_q;
    to_flag_d    = to_flag_q;
    cnt_d        = cnt_q;
    mem_op_c     = MemRead | MemWrite;
    addr_bad_c   = (ALUResult[1:0] != 2'b00);

    case (state_q)
      IDLE: begin
        if (inValid) begin
          alu_d        = ALUResult;
          store_d      = storeData;
          target_d     = branchTarget;
          dest_d       = destRegister;
          mem_read_d   = MemRead;
          mem_write_d  = MemWrite;
          mem_to_reg_d = MemToReg;
          reg_write_d  = RegWrite;
          branch_d     = Branch;
          zero_d       = zero;
          rdata_d      = '0;
          cnt_d        = '0;
          to_flag_d    = 1'b0;
          mis_flag_d   = mem_op_c & addr_bad_c;
          state_d      = (mem_op_c && !addr_bad_c) ? ACCESS : RESPOND;
        end
      end
      ACCESS: begin
        // Ack on the last allowed cycle still counts as a normal completion
        if (memAck) begin
          rdata_d = memReadData;
          state_d = RESPOND;
        end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
          to_flag_d = 1'b1;
          state_d   = RESPOND;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    is_load_c      = mem_read_d & ~mem_write_d;
    in_ready_d     = (state_d == IDLE);
    mem_request_d  = (state_d == ACCESS);
    mem_we_d       = (state_d == ACCESS) & mem_write_d;
    wb_valid_d     = (state_d == RESPOND);
    wb_reg_write_d = (state_d == RESPOND) & reg_write_d & ~mis_flag_d & ~to_flag_d & ~mem_write_d;
    branch_taken_d = (state_d == RESPOND) & branch_d & zero_d;
    misaligned_d   = (state_d == RESPOND) & mis_flag_d;
    timeout_d      = (state_d == RESPOND) & to_flag_d;
    wb_data_d      = wb_data_q;
    if (state_d == RESPOND) begin
      wb_data_d = (mem_to_reg_d & is_load_c) ? rdata_d : alu_d;
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q        <= IDLE;
      alu_q          <= '0;
      store_q        <= '0;
      target_q       <= '0;
      rdata_q        <= '0;
      dest_q         <= '0;
      mem_read_q     <= 1'b0;
      mem_write_q    <= 1'b0;
      mem_to_reg_q   <= 1'b0;
      reg_write_q    <= 1'b0;
      branch_q       <= 1'b0;
      zero_q         <= 1'b0;
      mis_flag_q     <= 1'b0;
      to_flag_q      <= 1'b0;
      cnt_q          <= '0;
      in_ready_q     <= 1'b1;
      mem_request_q  <= 1'b0;
      mem_we_q       <= 1'b0;
      wb_valid_q     <= 1'b0;
      wb_reg_write_q <= 1'b0;
      wb_data_q      <= '0;
      branch_taken_q <= 1'b0;
      misaligned_q   <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      alu_q          <= alu_d;
      store_q        <= store_d;
      target_q       <= target_d;
      rdata_q        <= rdata_d;
      dest_q         <= dest_d;
      mem_read_q     <= mem_read_d;
      mem_write_q    <= mem_write_d;
      mem_to_reg_q   <= mem_to_reg_d;
      reg_write_q    <= reg_write_d;
      branch_q       <= branch_d;
      zero_q         <= zero_d;
      mis_flag_q     <= mis_flag_d;
      to_flag_q      <= to_flag_d;
      cnt_q          <= cnt_d;
      in_ready_q     <= in_ready_d;
      mem_request_q  <= mem_request_d;
      mem_we_q       <= mem_we_d;
      wb_valid_q     <= wb_valid_d;
      wb_reg_write_q <= wb_reg_write_d;
      wb_data_q      <= wb_data_d;
      branch_taken_q <= branch_taken_d;
      misaligned_q   <= misaligned_d;
      timeout_q      <= timeout_d;
    end
  end

  assign inReady        = in_ready_q;
  assign memRequest     = mem_request_q;
  assign memWriteEnable = mem_we_q;
  assign memAddress     = alu_q;
  assign memWriteData   = store_q;
  assign wbValid        = wb_valid_q;
  assign wbRegWrite     = wb_reg_write_q;
  assign wbRegister     = dest_q;
  assign wbData         = wb_data_q;
  assign branchTaken    = branch_taken_q;
  assign branchAddress  = target_q;
  assign misaligned     = misaligned_q;
  assign timeoutError   = timeout_q;

endmodule

// File: tb/tb_memory_access_stage.sv
// Self-checking bench for memory_access_stage: directed plan items plus random ops
// checked against an operation-level reference model.
module tb_memory_access_stage;

  localparam int unsigned ACK_TIMEOUT = 15;

  logic        clock = 1'b0;
  logic        resetN;
  logic        inValid;
  logic        inReady;
  logic [31:0] ALUResult;
  logic        zero;
  logic [31:0] storeData;
  logic [4:0]  destRegister;
  logic        MemRead, MemWrite, MemToReg, RegWrite, Branch;
  logic [31:0] branchTarget;
  logic        memRequest;
  logic        memWriteEnable;
  logic [31:0] memAddress;
  logic [31:0] memWriteData;
  logic [31:0] memReadData;
  logic        memAck;
  logic        wbValid;
  logic        wbRegWrite;
  logic [4:0]  wbRegister;
  logic [31:0] wbData;
  logic        branchTaken;
  logic [31:0] branchAddress;
  logic        misaligned;
  logic        timeoutError;

  int tests = 0;
  int fails = 0;

  memory_access_stage #(.ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clock(clock), .resetN(resetN), .inValid(inValid), .inReady(inReady),
    .ALUResult(ALUResult), .zero(zero), .storeData(storeData), .destRegister(destRegister),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemToReg(MemToReg), .RegWrite(RegWrite),
    .Branch(Branch), .branchTarget(branchTarget), .memRequest(memRequest),
    .memWriteEnable(memWriteEnable), .memAddress(memAddress), .memWriteData(memWriteData),
    .memReadData(memReadData), .memAck(memAck), .wbValid(wbValid), .wbRegWrite(wbRegWrite),
    .wbRegister(wbRegister), .wbData(wbData), .branchTaken(branchTaken),
    .branchAddress(branchAddress), .misaligned(misaligned), .timeoutError(timeoutError)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic scramble_inputs();
    ALUResult    = $urandom;
    storeData    = $urandom;
    branchTarget = $urandom;
    destRegister = 5'($urandom);
    {MemRead, MemWrite, MemToReg, RegWrite, Branch, zero} = 6'($urandom);
  endtask

  // Drive one op, play the memory side (ack after ack_k cycles, 0 = never), check the result
  task automatic run_op(input logic mr, input logic mw, input logic m2r, input logic rw,
                        input logic br, input logic z, input logic [31:0] alu,
                        input logic [31:0] sd, input logic [31:0] tgt, input logic [4:0] dr,
                        input int ack_k, input logic [31:0] rd);
    bit mem_op, mis, acked, to, load, seen, addr_ok;
    int exp_lat, req_cyc, c;
    logic [31:0] exp_data;
    mem_op  = mr | mw;
    mis     = mem_op && (alu[1:0] != 2'b00);
    acked   = mem_op && !mis && ack_k >= 1 && ack_k <= int'(ACK_TIMEOUT);
    to      = mem_op && !mis && !acked;
    load    = mem_op && !mw;
    exp_lat = (!mem_op || mis) ? 0 : (acked ? ack_k : int'(ACK_TIMEOUT));
    exp_data = (m2r && load) ? rd : alu;

    c = 0;
    while (!inReady && c < 10) begin
      step();
      c++;
    end
    check("ready_before_op", 32'(inReady), 32'd1);

    MemRead = mr; MemWrite = mw; MemToReg = m2r; RegWrite = rw; Branch = br; zero = z;
    ALUResult = alu; storeData = sd; branchTarget = tgt; destRegister = dr;
    inValid = 1'b1;
    step();
    inValid = 1'b0;
    scramble_inputs();

    seen = 0; req_cyc = 0; c = 0; addr_ok = 1;
    while (!seen && c <= int'(ACK_TIMEOUT) + 5) begin
      if (wbValid) begin
        seen = 1;
      end else begin
        if (memRequest) begin
          req_cyc++;
          if (memAddress !== alu || memWriteData !== sd || memWriteEnable !== mw) addr_ok = 0;
        end
        memAck      = acked && (c == ack_k - 1);
        memReadData = memAck ? rd : $urandom;
        step();
        c++;
      end
    end
    memAck = 1'b0;

    check("wb_seen", 32'(seen), 32'd1);
    check("latency", 32'(c), 32'(exp_lat));
    check("request_cycles", 32'(req_cyc), 32'(exp_lat));
    check("request_stable", 32'(addr_ok), 32'd1);
    if (seen) begin
      check("wbRegWrite", 32'(wbRegWrite), 32'(rw && !mis && !to && !mw));
      check("wbRegister", 32'(wbRegister), 32'(dr));
      check("branchTaken", 32'(branchTaken), 32'(br && z));
      check("branchAddress", branchAddress, tgt);
      check("misaligned", 32'(misaligned), 32'(mis));
      check("timeoutError", 32'(timeoutError), 32'(to));
      check("req_low_in_wb", 32'(memRequest), 32'd0);
      check("ready_low_in_wb", 32'(inReady), 32'd0);
      if (!mis && !to) check("wbData", wbData, exp_data);
    end
    step();
    check("wb_one_cycle", 32'(wbValid), 32'd0);
    check("ready_after_wb", 32'(inReady), 32'd1);
    check("flags_clear", 32'({misaligned, timeoutError}), 32'd0);
  endtask

  initial begin
    bit saw_wb;
    resetN = 1'b0;
    inValid = 1'b0; memAck = 1'b0; memReadData = '0;
    ALUResult = '0; storeData = '0; branchTarget = '0; destRegister = '0;
    {MemRead, MemWrite, MemToReg, RegWrite, Branch, zero} = '0;
    #12;
    check("rst_inReady", 32'(inReady), 32'd1);
    check("rst_memRequest", 32'(memRequest), 32'd0);
    check("rst_wbValid", 32'(wbValid), 32'd0);
    check("rst_wbRegWrite", 32'(wbRegWrite), 32'd0);
    check("rst_memAddress", memAddress, 32'd0);
    check("rst_flags", 32'({misaligned, timeoutError, branchTaken, memWriteEnable}), 32'd0);
    resetN = 1'b1;
    step();

    // ALU op writeback
    run_op(0, 0, 0, 1, 0, 0, 32'h0000_002A, 32'h0, 32'h0, 5'd5, 0, 32'h0);
    // Load, ack after 3 cycles
    run_op(1, 0, 1, 1, 0, 0, 32'h0000_0100, 32'h0, 32'h0, 5'd7, 3, 32'hDEADBEEF);
    // Store with RegWrite set: no register write
    run_op(0, 1, 0, 1, 0, 0, 32'h0000_0104, 32'h0000_1234, 32'h0, 5'd9, 2, 32'h0);
    // Read+write both set: store wins
    run_op(1, 1, 1, 1, 0, 0, 32'h0000_0208, 32'hCAFE_0001, 32'h0, 5'd3, 1, 32'h5555_AAAA);
    // Misaligned load
    run_op(1, 0, 1, 1, 0, 0, 32'h0000_0102, 32'h0, 32'h0, 5'd4, 1, 32'h0);
    // Taken branch
    run_op(0, 0, 0, 0, 1, 1, 32'h0, 32'h0, 32'h0000_0040, 5'd0, 0, 32'h0);
    // Timeout, then a late ack that must be ignored
    run_op(1, 0, 1, 1, 0, 0, 32'h0000_0300, 32'h0, 32'h0, 5'd11, 0, 32'h0);
    memAck = 1'b1;
    step();
    memAck = 1'b0;
    check("late_ack_no_wb", 32'(wbValid), 32'd0);
    check("late_ack_no_req", 32'(memRequest), 32'd0);
    // Ack on the final allowed cycle
    run_op(1, 0, 1, 1, 0, 0, 32'h0000_0304, 32'h0, 32'h0, 5'd12, int'(ACK_TIMEOUT), 32'h1357_9BDF);

    // Reset while ACCESS is outstanding
    MemRead = 1'b1; MemWrite = 1'b0; MemToReg = 1'b1; RegWrite = 1'b1; Branch = 1'b0;
    ALUResult = 32'h0000_0400; destRegister = 5'd6;
    inValid = 1'b1;
    step();
    inValid = 1'b0;
    step();
    step();
    check("mid_access_req", 32'(memRequest), 32'd1);
    resetN = 1'b0;
    #1;
    check("reset_drops_req", 32'(memRequest), 32'd0);
    check("reset_ready", 32'(inReady), 32'd1);
    #3;
    resetN = 1'b1;
    saw_wb = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (wbValid) saw_wb = 1;
    end
    check("no_wb_after_reset", 32'(saw_wb), 32'd0);
    run_op(1, 0, 1, 1, 0, 0, 32'h0000_0400, 32'h0, 32'h0, 5'd6, 2, 32'h0BAD_F00D);

    // Random operations
    for (int n = 0; n < 25; n++) begin
      logic [31:0] a;
      int k;
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      k = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, ACK_TIMEOUT));
      run_op(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom), a, $urandom, $urandom, 5'($urandom), k, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
